// File: rtl/console_pkg.sv
// Shared constants and types for the console read-out path.
package console_pkg;

  localparam int unsigned DEF_LINES   = 8;
  localparam int unsigned DEF_COLUMNS = 32;
  localparam int unsigned LOC_W       = $clog2(DEF_LINES * DEF_COLUMNS);

  localparam logic [7:0] CHAR_LF = 8'd10;
  localparam logic [7:0] CHAR_CR = 8'd13;
  localparam logic [7:0] BLANK   = 8'h20;

  typedef logic [LOC_W-1:0] loc_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN
  } console_state_t;

endpackage

// File: rtl/console_char_ram.sv
// Simple dual-port character RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the new data.
module console_char_ram #(
  parameter int unsigned Depth     = 256,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  // Storage and registered read; contents are deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/console_reader.sv
// Console storage and read-out: captures writer strobes into a character RAM
// and streams the whole screen over a valid/ready interface.
// Optional feature macro: CONSOLE_READER_CURSOR_EN (cursor flag on beats).
module console_reader #(
  parameter int unsigned LINES   = console_pkg::DEF_LINES,
  parameter int unsigned COLUMNS = console_pkg::DEF_COLUMNS,
  parameter logic [7:0]  BLANK   = console_pkg::BLANK,
  // Derived from the screen geometry; not meant to be overridden.
  parameter int unsigned AW      = $clog2(LINES * COLUMNS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          write_flag,
  input  logic          clear_flag,
  input  logic [AW-1:0] location,
  input  logic [7:0]    character,
  input  logic          frame_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_char,
  output logic [AW-1:0] out_location,
  output logic          out_last,
  output logic          out_cursor,
  output logic          busy
);
  import console_pkg::*;

  localparam int unsigned   N        = LINES * COLUMNS;
  localparam logic [AW-1:0] LAST_LOC = AW'(N - 1);

  console_state_t state_q, state_d;
  logic           boot_q, boot_d;
  logic           frame_pend_q, frame_pend_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [AW:0]    rd_cnt_q, rd_cnt_d;

  logic           pend_q, pend_d;
  logic [AW-1:0]  pend_loc_q, pend_loc_d;
  logic           hold_vld_q, hold_vld_d;
  logic [7:0]     hold_char_q, hold_char_d;
  logic [AW-1:0]  hold_loc_q, hold_loc_d;

  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_char_q, out_char_d;
  logic [AW-1:0]  out_loc_q, out_loc_d;
  logic           out_last_q, out_last_d;
  logic           out_cursor_q, out_cursor_d;

  logic           ram_we, ram_re;
  logic [AW-1:0]  ram_waddr, ram_raddr;
  logic [7:0]     ram_wdata, ram_rdata;

  logic           xfer, is_lf_cr, clear_req, enter_clear, scan_start;
  logic           issue, load_out, src_vld, cursor_hit;
  logic [1:0]     occ_next;
  logic [7:0]     src_char;
  logic [AW-1:0]  src_loc;

  assign xfer        = out_valid_q && out_ready;
  assign is_lf_cr    = (character == CHAR_LF) || (character == CHAR_CR);
  // boot_q forces the automatic clear on the first edge after reset.
  assign clear_req   = boot_q || clear_flag;
  assign enter_clear = (state_q != CLEAR) && clear_req;
  assign scan_start  = (state_q != SCAN) && (state_d == SCAN);

  // FSM next state, clear sweep counter and pending-frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    boot_d       = 1'b0;
    frame_pend_d = frame_pend_q;
    clr_cnt_d    = clr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          if (frame_start) frame_pend_d = 1'b1;
        end else if (frame_start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          if (frame_start) frame_pend_d = 1'b1;
        end else if (xfer && out_last_q) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (frame_start) frame_pend_d = 1'b1;
        if (clr_cnt_q == LAST_LOC) begin
          if (frame_pend_q || frame_start) begin
            state_d      = SCAN;
            frame_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM write port: blank sweep during CLEAR, writer strobes otherwise.
  always_comb begin
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = BLANK;
    end else begin
      ram_we    = write_flag && !is_lf_cr;
      ram_waddr = location;
      ram_wdata = character;
    end
  end

  // Entries held in out/hold once in-flight data lands, assuming no new read.
  // A read is only issued if its data is guaranteed a slot even under stall.
  assign occ_next = 2'(out_valid_q) + 2'(hold_vld_q) + 2'(pend_q) - 2'(xfer);
  assign issue    = (state_q == SCAN) && !rd_cnt_q[AW] && (occ_next <= 2'd1);
  assign ram_re   = issue;
  assign ram_raddr = rd_cnt_q[AW-1:0];

  assign load_out = !out_valid_q || xfer;
  assign src_vld  = hold_vld_q || pend_q;
  assign src_char = hold_vld_q ? hold_char_q : ram_rdata;
  assign src_loc  = hold_vld_q ? hold_loc_q : pend_loc_q;

`ifdef CONSOLE_READER_CURSOR_EN
  logic [AW-1:0] cursor_q, cursor_d;

  // Cursor follows the last writer location; cleared when a sweep starts.
  always_comb begin
    cursor_d = cursor_q;
    if (enter_clear) begin
      cursor_d = '0;
    end else if (write_flag && (state_q != CLEAR)) begin
      cursor_d = location;
    end
  end

  // Cursor register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_q <= '0;
    end else begin
      cursor_q <= cursor_d;
    end
  end

  assign cursor_hit = (src_loc == cursor_q);
`else
  assign cursor_hit = 1'b0;
`endif

  // Read-ahead pipeline: RAM output feeds the output register directly, or
  // parks in the holding register while the consumer stalls.
  always_comb begin
    pend_d       = issue;
    pend_loc_d   = rd_cnt_q[AW-1:0];
    rd_cnt_d     = rd_cnt_q + (AW+1)'(issue);
    hold_vld_d   = hold_vld_q;
    hold_char_d  = hold_char_q;
    hold_loc_d   = hold_loc_q;
    out_valid_d  = out_valid_q;
    out_char_d   = out_char_q;
    out_loc_d    = out_loc_q;
    out_last_d   = out_last_q;
    out_cursor_d = out_cursor_q;
    if (load_out) begin
      out_valid_d = src_vld;
      if (src_vld) begin
        out_char_d   = src_char;
        out_loc_d    = src_loc;
        out_last_d   = (src_loc == LAST_LOC);
        out_cursor_d = cursor_hit;
      end
      hold_vld_d = hold_vld_q && pend_q;
      if (hold_vld_q && pend_q) begin
        hold_char_d = ram_rdata;
        hold_loc_d  = pend_loc_q;
      end
    end else if (pend_q) begin
      hold_vld_d  = 1'b1;
      hold_char_d = ram_rdata;
      hold_loc_d  = pend_loc_q;
    end
    if (enter_clear) begin
      out_valid_d = 1'b0;
      hold_vld_d  = 1'b0;
      pend_d      = 1'b0;
    end
    if (scan_start) begin
      rd_cnt_d = '0;
    end
  end

  // State, counter and pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      boot_q       <= 1'b1;
      frame_pend_q <= 1'b0;
      clr_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      pend_q       <= 1'b0;
      pend_loc_q   <= '0;
      hold_vld_q   <= 1'b0;
      hold_char_q  <= '0;
      hold_loc_q   <= '0;
      out_valid_q  <= 1'b0;
      out_char_q   <= '0;
      out_loc_q    <= '0;
      out_last_q   <= 1'b0;
      out_cursor_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_q       <= boot_d;
      frame_pend_q <= frame_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      pend_q       <= pend_d;
      pend_loc_q   <= pend_loc_d;
      hold_vld_q   <= hold_vld_d;
      hold_char_q  <= hold_char_d;
      hold_loc_q   <= hold_loc_d;
      out_valid_q  <= out_valid_d;
      out_char_q   <= out_char_d;
      out_loc_q    <= out_loc_d;
      out_last_q   <= out_last_d;
      out_cursor_q <= out_cursor_d;
    end
  end

  console_char_ram #(
    .Depth     (N),
    .AddrWidth (AW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign out_valid    = out_valid_q;
  assign out_char     = out_char_q;
  assign out_location = out_loc_q;
  assign out_last     = out_last_q;
  assign out_cursor   = out_cursor_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/console_reader.md
# console_reader

Storage and read-out end of the console path. Captures the `write_flag`/`clear_flag`/`location`/`character` stream produced by the console writer into a character RAM of LINES×COLUMNS cells. Streams the whole screen, cell by cell, to a display consumer over a valid/ready interface. Sits between the console writer and the display driver.

## Interface
- `LINES`, 8: screen lines; power of two.
- `COLUMNS`, 32: cells per line; power of two.
- `BLANK`, 8'h20: fill character written by clear.
- `clock`  in  1  sole clock; all logic on posedge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `write_flag`  in  1  writer strobe: store `character` at `location`.
- `clear_flag`  in  1  writer strobe: blank the screen.
- `location`  in  AW = $clog2(LINES*COLUMNS) (8)  cell address, `{line, index}`.
- `character`  in  8  character to store.
- `frame_start`  in  1  request one full-screen read-out.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts beat.
- `out_char`  out  8  character of beat.
- `out_location`  out  AW  cell address of beat.
- `out_last`  out  1  beat is cell N-1 (N = LINES*COLUMNS).
- `out_cursor`  out  1  beat is the cursor cell (see Configuration).
- `busy`  out  1  high in CLEAR or SCAN.

## Operation
- FSM states: IDLE, CLEAR, SCAN.
- Writes:
  - `write_flag` in IDLE or SCAN with `character` ∉ {10, 13} → `mem[location] <= character`.
  - LF (10) and CR (13) are never stored.
  - Writes in CLEAR are dropped.
- Clear sweep:
  - Address counter runs 0..N-1, writing BLANK one cell per cycle, N cycles total, then → IDLE.
  - The first clock edge after reset release enters CLEAR automatically.
  - `clear_flag` in IDLE or SCAN → CLEAR; an active scan is aborted and `out_valid` drops at the next edge.
  - `clear_flag` in CLEAR is ignored (no restart).
- Scan:
  - `frame_start` in IDLE → SCAN at address 0.
  - `frame_start` in SCAN is ignored.
  - `frame_start` in CLEAR is latched as pending; SCAN starts on the cycle CLEAR completes.
- Beats are emitted in address order 0..N-1. A transfer occurs on `out_valid && out_ready`. After the transfer with `out_last=1` → IDLE.
- Simultaneous `clear_flag` and `frame_start`: clear wins; the frame is left pending.
- Write/read hazard:
  - A write to a cell not yet read in the current scan is visible in that scan.
  - A beat already registered on the output is not updated.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `out_cursor`, `busy` = 0.
  - `out_char` = 0; `out_location` = 0.
  - State IDLE; pending-frame flag 0.
  - RAM contents are unreset (the automatic clear covers them).
- `busy`:
  - Rises 1 cycle after reset release.
  - Stays high N cycles for the initial CLEAR.
  - Falls the cycle after the final beat transfer or the final clear write.
- RAM: synchronous read, 1-cycle latency.
- Scan latency: `frame_start` sampled at edge k → `out_valid` high after edge k+2.
- Throughput: 1 beat/cycle sustained with `out_ready` held high; a read-ahead holding register hides the RAM latency.
- Backpressure: while `out_valid && !out_ready`, `out_char`, `out_location`, `out_last` and `out_cursor` hold stable.
- `out_valid` never deasserts without a transfer, except on clear abort or reset.
- Asynchronous reset mid-scan or mid-clear → all outputs return to reset values immediately; the automatic CLEAR follows.

## Configuration
- `CONSOLE_READER_CURSOR_EN` defined:
  - A cursor register (AW bits, reset 0) captures `location` on every `write_flag` outside CLEAR, including LF/CR.
  - The cursor register resets to 0 on entry to CLEAR.
  - `out_cursor = (out_location == cursor)` for each beat.
- Undefined: no cursor register; `out_cursor` tied 0. Port list unchanged.

## Structure
- Package `console_pkg` holds:
  - `LINES`/`COLUMNS` defaults.
  - `CHAR_LF = 8'd10`, `CHAR_CR = 8'd13`, `BLANK`.
  - `loc_t` (AW-bit location typedef).
  - FSM enum `console_state_t {IDLE, CLEAR, SCAN}`.
- One sub-module: `console_char_ram`, a simple dual-port N×8 RAM with one write port and one synchronous read port.
- FSM, counters, read-ahead and output register stay in `console_reader`.

## Test plan
- Reset release → `busy` high for 256 cycles; a following frame yields 256 beats of 0x20 with `out_last` only on location 255.
- Write 0x41 at location 0x25, then `frame_start` with `out_ready`=1 → beat 37 carries 0x41 and all others 0x20; beats are back-to-back; first `out_valid` 2 cycles after `frame_start`.
- `out_ready` low for 5 cycles at beat 10 → beat 10 (char, location, last) held stable; no beat lost or duplicated; 256 beats total.
- `clear_flag` asserted after beat 100 transfers → `out_valid` low next cycle; `busy` high 256 cycles; a subsequent frame is all 0x20.
- `write_flag` with `character` 10 and 13 at location 0x05 → the cell stays 0x20; a `write_flag` during CLEAR is dropped.
- With `CONSOLE_READER_CURSOR_EN`: write 0x42 at location 0x47, then scan → `out_cursor`=1 only on beat 71. Without the macro, `out_cursor` is 0 on every beat.
